// File: rtl/hack_ram_loader.sv
// Framed byte-stream loader for the Hack data RAM: length header, big-endian payload words, additive checksum trailer.
// Writes are registered one-cycle ram_load pulses; the CPU is held in reset (cpu_hold) for the whole load.
module hack_ram_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 16384
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  ram_load,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_in_data,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [31:0]           MAX_N = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, DONE_ST
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            byte_hi;
  logic [15:0]           len;
  logic [15:0]           sum;
  logic                  xfer;
  logic [15:0]           rx_word;
  logic [ADDR_WIDTH:0]   wl_next;
  logic                  len_bad;
  logic                  more_words;

  assign xfer       = in_valid && in_ready;
  assign rx_word    = {byte_hi, in_data};
  assign wl_next    = words_loaded + 1'b1;
  assign len_bad    = 32'(rx_word) > MAX_N;
  assign more_words = 32'(wl_next) < 32'(len);
  assign cpu_hold   = busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LEN_HI;
      LEN_HI:  if (xfer) state_nxt = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (len_bad)           state_nxt = DONE_ST;
          else if (rx_word == 0) state_nxt = CSUM_HI;
          else                   state_nxt = DATA_HI;
        end
      end
      DATA_HI: if (xfer) state_nxt = DATA_LO;
      DATA_LO: if (xfer) state_nxt = more_words ? DATA_HI : CSUM_HI;
      CSUM_HI: if (xfer) state_nxt = CSUM_LO;
      CSUM_LO: if (xfer) state_nxt = DONE_ST;
      DONE_ST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO: in_ready = 1'b1;
      default:                                            in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_load     <= 1'b0;
      ram_addr     <= BASE;
      ram_in_data  <= 16'h0000;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      byte_hi      <= 8'h00;
      len          <= 16'h0000;
      sum          <= 16'h0000;
    end else begin
      ram_load <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            sum          <= 16'h0000;
            ram_addr     <= BASE;
            busy         <= 1'b1;
          end
        end
        LEN_HI, DATA_HI, CSUM_HI: begin
          if (xfer) byte_hi <= in_data;
        end
        LEN_LO: begin
          if (xfer) begin
            len <= rx_word;
            // An oversized length ends the load without consuming the rest of the frame
            if (len_bad) begin
              error <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        DATA_LO: begin
          if (xfer) begin
            ram_in_data  <= rx_word;
            ram_addr     <= BASE + words_loaded[ADDR_WIDTH-1:0];
            ram_load     <= 1'b1;
            sum          <= sum + rx_word;
            words_loaded <= wl_next;
          end
        end
        CSUM_LO: begin
          if (xfer) begin
            error <= (rx_word != sum);
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_ram_loader.sv
// Directed bench for hack_ram_loader with a behavioural RAM capturing each ram_load pulse.
module tb_hack_ram_loader;

  localparam int AW = 14;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          ram_load;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_in_data;
  logic          busy;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int asserts  = 0;
  int failures = 0;

  logic [15:0] mem [0:63];
  int          log_addr [$];
  logic [15:0] log_dat  [$];
  logic        prev_load = 1'b0;
  int          dbl_cnt   = 0;
  int          hold_err  = 0;
  logic [15:0] pl [0:15];

  hack_ram_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .MAX_WORDS(16384)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_load(ram_load), .ram_addr(ram_addr), .ram_in_data(ram_in_data),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_load) begin
      mem[ram_addr[5:0]] <= ram_in_data;
      log_addr.push_back(int'(ram_addr));
      log_dat.push_back(ram_in_data);
    end
    if (ram_load && prev_load) dbl_cnt++;
    prev_load <= ram_load;
  end

  always @(negedge clock) if (cpu_hold !== busy) hold_err++;

  function automatic logic [15:0] calc_sum(input int n);
    logic [15:0] s = 16'h0000;
    for (int i = 0; i < n; i++) s = s + pl[i];
    return s;
  endfunction

  task automatic clear_log();
    log_addr.delete();
    log_dat.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    int n;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    if (g > 0) begin
      in_valid = 1'b0;
      repeat (g) @(negedge clock);
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    asserts++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_byte: in_ready=%b after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
    end else begin
      @(negedge clock);
    end
  endtask

  task automatic send_load(input int n, input logic [15:0] csum, input int max_gap);
    send_byte(8'(n >> 8), max_gap);
    send_byte(8'(n), max_gap);
    for (int i = 0; i < n; i++) begin
      send_byte(pl[i][15:8], max_gap);
      send_byte(pl[i][7:0], max_gap);
    end
    send_byte(csum[15:8], max_gap);
    send_byte(csum[7:0], max_gap);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    asserts++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s wait_done: done=%b, required 1", name, done);
    end
  endtask

  task automatic check_log(input string name, input int n);
    asserts++;
    if (log_addr.size() != n) begin
      failures++;
      $display("FAIL %s log size: got %0d, required %0d", name, log_addr.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        asserts++;
        if (log_addr[i] != i || log_dat[i] !== pl[i]) begin
          failures++;
          $display("FAIL %s write %0d: addr=%0d data=%h, required addr=%0d data=%h",
                   name, i, log_addr[i], log_dat[i], i, pl[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clock);
    asserts++;
    if ({in_ready, ram_load, busy, cpu_hold, done, error} !== 6'b0) begin
      failures++;
      $display("FAIL reset flags: got %b, required 000000",
               {in_ready, ram_load, busy, cpu_hold, done, error});
    end
    asserts++;
    if (ram_addr !== '0 || ram_in_data !== 16'h0 || words_loaded !== '0) begin
      failures++;
      $display("FAIL reset regs: addr=%h data=%h wl=%0d, required 0 0 0",
               ram_addr, ram_in_data, words_loaded);
    end
    reset = 1'b0;
    @(negedge clock);
    asserts++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle: in_ready=%b busy=%b, required 0 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    pl[0] = 16'h1234; pl[1] = 16'hABCD; pl[2] = 16'h0001;
    clear_log();
    pulse_start();
    asserts++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic start: busy=%b hold=%b rdy=%b, required 1 1 1", busy, cpu_hold, in_ready);
    end
    send_load(3, 16'hBE02, 0);
    wait_done("basic");
    asserts++;
    if (error !== 1'b0 || words_loaded !== 15'd3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic status: err=%b wl=%0d busy=%b, required 0 3 0", error, words_loaded, busy);
    end
    check_log("basic", 3);
    asserts++;
    if (mem[0] !== 16'h1234 || mem[1] !== 16'hABCD || mem[2] !== 16'h0001) begin
      failures++;
      $display("FAIL basic ram: %h %h %h, required 1234 abcd 0001", mem[0], mem[1], mem[2]);
    end
  endtask

  task automatic test_csum_err();
    clear_log();
    pulse_start();
    send_load(3, 16'hBE03, 0);
    wait_done("csum_err");
    asserts++;
    if (error !== 1'b1 || words_loaded !== 15'd3) begin
      failures++;
      $display("FAIL csum_err status: err=%b wl=%0d, required 1 3", error, words_loaded);
    end
    check_log("csum_err", 3);
  endtask

  task automatic test_zero_len();
    clear_log();
    pulse_start();
    send_load(0, 16'h0000, 0);
    wait_done("zero_len");
    asserts++;
    if (error !== 1'b0 || words_loaded !== '0 || log_addr.size() != 0) begin
      failures++;
      $display("FAIL zero_len: err=%b wl=%0d writes=%0d, required 0 0 0",
               error, words_loaded, log_addr.size());
    end
  endtask

  task automatic test_len_err();
    clear_log();
    pulse_start();
    send_byte(8'h40, 0);
    send_byte(8'h01, 0);
    asserts++;
    if (in_ready !== 1'b0 || done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL len_err after LEN_LO: rdy=%b done=%b err=%b busy=%b, required 0 1 1 0",
               in_ready, done, error, busy);
    end
    in_data = 8'h55;
    repeat (3) @(negedge clock);
    asserts++;
    if (in_ready !== 1'b0 || done !== 1'b1 || error !== 1'b1 || log_addr.size() != 0) begin
      failures++;
      $display("FAIL len_err idle: rdy=%b done=%b err=%b writes=%0d, required 0 1 1 0",
               in_ready, done, error, log_addr.size());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_gaps();
    int          ref_addr [$];
    logic [15:0] ref_dat  [$];
    for (int i = 0; i < 16; i++) pl[i] = 16'((i * 16'h1357) ^ 16'hA5C3);
    clear_log();
    pulse_start();
    send_load(16, calc_sum(16), 0);
    wait_done("nogap");
    ref_addr = log_addr;
    ref_dat  = log_dat;
    check_log("nogap", 16);
    clear_log();
    dbl_cnt = 0;
    pulse_start();
    send_load(16, calc_sum(16), 3);
    wait_done("gaps");
    asserts++;
    if (error !== 1'b0 || words_loaded !== 15'd16) begin
      failures++;
      $display("FAIL gaps status: err=%b wl=%0d, required 0 16", error, words_loaded);
    end
    asserts++;
    if (log_addr != ref_addr || log_dat != ref_dat) begin
      failures++;
      $display("FAIL gaps vs nogap: writes=%0d differ from %0d reference writes",
               log_addr.size(), ref_addr.size());
    end
    check_log("gaps", 16);
    asserts++;
    if (dbl_cnt != 0) begin
      failures++;
      $display("FAIL gaps ram_load consecutive: %0d, required 0", dbl_cnt);
    end
  endtask

  task automatic test_reset_mid();
    pl[0] = 16'h0101; pl[1] = 16'h0202; pl[2] = 16'h0303; pl[3] = 16'h0404; pl[4] = 16'h0505;
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    for (int i = 0; i < 2; i++) begin
      send_byte(pl[i][15:8], 0);
      send_byte(pl[i][7:0], 0);
    end
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    asserts++;
    if ({in_ready, ram_load, busy, cpu_hold, done, error} !== 6'b0 || words_loaded !== '0
        || ram_addr !== '0) begin
      failures++;
      $display("FAIL reset_mid: flags=%b wl=%0d addr=%0d, required 000000 0 0",
               {in_ready, ram_load, busy, cpu_hold, done, error}, words_loaded, ram_addr);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_log("reset_mid", 2);
    clear_log();
    pulse_start();
    send_load(5, calc_sum(5), 0);
    wait_done("reload");
    asserts++;
    if (error !== 1'b0 || words_loaded !== 15'd5) begin
      failures++;
      $display("FAIL reload status: err=%b wl=%0d, required 0 5", error, words_loaded);
    end
    check_log("reload", 5);
  endtask

  task automatic test_start_busy();
    pl[0] = 16'hCAFE; pl[1] = 16'h0F0F;
    clear_log();
    hold_err = 0;
    dbl_cnt  = 0;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hCA, 0);
    in_valid = 1'b0;
    pulse_start();
    send_byte(8'hFE, 0);
    send_byte(8'h0F, 0);
    in_valid = 1'b0;
    pulse_start();
    send_byte(8'h0F, 0);
    send_byte(8'hDA, 0);
    send_byte(8'h0D, 0);
    in_valid = 1'b0;
    wait_done("start_busy");
    asserts++;
    if (error !== 1'b0 || words_loaded !== 15'd2) begin
      failures++;
      $display("FAIL start_busy status: err=%b wl=%0d, required 0 2", error, words_loaded);
    end
    check_log("start_busy", 2);
    asserts++;
    if (hold_err != 0 || dbl_cnt != 0) begin
      failures++;
      $display("FAIL start_busy hold/load: hold_err=%0d dbl=%0d, required 0 0", hold_err, dbl_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_csum_err();
    test_zero_len();
    test_len_err();
    test_gaps();
    test_reset_mid();
    test_start_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/hack_ram_loader.md
Name: hack_ram_loader

Overview:
- Byte-stream program/data loader sitting directly upstream of the Hack data RAM; drives its load/address/write-data inputs.
- Receives a framed byte stream (length header, payload words, checksum trailer) over a valid/ready interface.
- Writes the payload into consecutive RAM words starting at BASE_ADDR, verifies a 16-bit additive checksum, and holds the CPU in reset while loading.

Parameters:
ADDR_WIDTH, 14, RAM word-address width.
BASE_ADDR, 0, first RAM word address written.
MAX_WORDS, 16384, largest accepted payload length in words; must satisfy BASE_ADDR+MAX_WORDS <= 2^ADDR_WIDTH.

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; begins a new load when not busy.
in_valid  input  1  byte-stream valid.
in_data  input  8  byte-stream data.
in_ready  output  1  loader can accept a byte this cycle.
ram_load  output  1  RAM write enable, registered one-cycle pulse.
ram_addr  output  ADDR_WIDTH  RAM word address, registered.
ram_in_data  output  16  RAM write data, registered.
busy  output  1  load in progress.
cpu_hold  output  1  CPU reset request; equals busy.
done  output  1  sticky; load finished (success or error).
error  output  1  sticky; valid only with done: 1 = bad length or checksum mismatch.
words_loaded  output  ADDR_WIDTH+1  count of words written in current/last load.

Behaviour:
- Reset (async, immediate): state IDLE; in_ready, ram_load, busy, cpu_hold, done, error = 0; ram_addr = BASE_ADDR; ram_in_data = 0; words_loaded = 0; internal length/sum/byte latch = 0.
- Byte transfer occurs on a rising edge when in_valid && in_ready. in_ready is 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO; in_data ignored otherwise.
- All multi-byte fields big-endian (high byte first).
- States/transitions:
  IDLE: start -> LEN_HI; clear done, error, words_loaded, sum; ram_addr = BASE_ADDR; busy=1.
  LEN_HI: byte -> latch high -> LEN_LO.
  LEN_LO: byte -> N = {hi,lo}. N > MAX_WORDS -> DONE with error=1. N == 0 -> CSUM_HI. Else -> DATA_HI.
  DATA_HI: byte -> latch -> DATA_LO.
  DATA_LO: byte -> on same edge ram_in_data <= {hi,lo}, ram_addr <= BASE_ADDR+words_loaded, ram_load <= 1, sum <= sum+word mod 2^16, words_loaded++; next state DATA_HI if words_loaded+1 < N else CSUM_HI.
  CSUM_HI: byte -> latch -> CSUM_LO.
  CSUM_LO: byte -> error <= ({hi,lo} != sum) -> DONE.
  DONE: done=1, busy=0 (both registered, visible cycle after entry edge); -> IDLE on next cycle while done/error remain sticky until next accepted start.
- ram_load is high exactly one cycle per word, the cycle after the DATA_LO byte; RAM captures on that next rising edge. Because each word takes >=2 bytes, ram_load is never high two consecutive cycles. ram_addr/ram_in_data hold their last values when ram_load=0.
- Throughput: one byte per cycle with in_valid held high; N words fully written within 2N+4 byte transfers plus 1 cycle.
- start while busy: ignored. start in same cycle as reset: reset wins.
- Stalls (in_valid low) in any state: hold state, no side effects.
- Reset mid-load: immediate abort; words already written remain in RAM; no ram_load pulse after reset asserts.
- Length error: no RAM writes occur; remaining stream bytes are not consumed.
- Checksum error: payload words are already written; only error flags it.
- words_loaded saturates at N (never exceeds MAX_WORDS).

Test Plan:
- Reset then start, stream 00 03 | 12 34 | AB CD | 00 01 | BE 02 (sum 0x1234+0xABCD+0x0001=0xBE02) -> ram_load 3 pulses at addrs 0,1,2 with 0x1234,0xABCD,0x0001; done=1, error=0, words_loaded=3; RAM readback matches.
- Same payload, trailer BE 03 -> all 3 words written, done=1, error=1.
- Length 00 00 then trailer 00 00 -> no ram_load, done=1, error=0; length 40 01 (16385) -> no ram_load, done=1, error=1, in_ready=0 after LEN_LO.
- Random in_valid gaps over 16-word load -> identical RAM contents/addresses as gap-free run; ram_load never high two consecutive cycles.
- Assert reset after 2nd word's ram_load of 5-word load -> all outputs to reset values immediately; words 0-1 in RAM, no further writes; new start reloads correctly.
- start pulsed during active load -> ignored; load completes with original N; cpu_hold tracks busy throughout.
